dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_pkg.sv | 18 +
 rtl/dmem_resp_if.sv | 28 ++
 rtl/dmem_resp_ram.sv | 35 +++
 rtl/dmem_resp.sv | 158 +++++++++++++++
 tb/tb_dmem_resp.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg
//   Shared types and constants for the dmem_resp data-memory responder.
//   Contents:
//     state_t             controller state encoding
//     MAILBOX_ADR_DEFAULT default byte address of the test-result mailbox
//     WAIT_CNT_W          width of the wait-state down-counter (covers 0..15)
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] MAILBOX_ADR_DEFAULT = 32'h0000_0ffc;
    localparam int          WAIT_CNT_W          = 4;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if
//   Processor <-> data-memory handshake bundle.
//   Signals:
//     memwrite, memread  request strobes, held by the processor until memready
//     dataadr            byte address
//     writedata, byteen  store data and per-byte enables
//     readdata           load data, non-zero only during the completion cycle
//     memready           one-cycle completion strobe
//   Modports: master (processor side), slave (memory side).
interface dmem_resp_if;
    logic        memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [3:0]  byteen;
    logic [31:0] readdata;
    logic        memready;

    modport master (
        output memwrite, memread, dataadr, writedata, byteen,
        input  readdata, memready
    );

    modport slave (
        input  memwrite, memread, dataadr, writedata, byteen,
        output readdata, memready
    );
endinterface

// File: rtl/dmem_resp_ram.sv
// dmem_resp_ram
//   Word-organised storage: one byte-enabled write port and one synchronous
//   read port. Contents are never reset.
//   Ports:
//     clk    clock
//     we     write enable
//     be     per-byte write enables
//     wadr   write word index
//     wdata  write data
//     radr   read word index (sampled on the rising edge)
//     rdata  registered read data
module dmem_resp_ram #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wadr,
    input  logic [31:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] radr,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[wadr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[radr];
    end
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp
//   Wait-state data-memory responder with sticky out-of-range flag and an
//   optional test-result mailbox (enabled by defining DMEM_RESP_MAILBOX_EN).
//   Ports:
//     clk         clock
//     reset       asynchronous active-high reset
//     bus         dmem_resp_if.slave request/response bundle
//     oob         sticky: a request addressed beyond DEPTH_WORDS completed
//     mbox_valid  sticky: mailbox written
//     mbox_pass   last mailbox write equalled EXPECT_DATA
//     mbox_data   last mailbox write value
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for memwrite|memread; request latched on accept
//   WAIT    | counting down wait states
//   RESP    | memready high one cycle; write commits on the closing edge
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MAILBOX_ADR = MAILBOX_ADR_DEFAULT,
    parameter logic [31:0] EXPECT_DATA = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        reset,
    dmem_resp_if.slave  bus,
    output logic        oob,
    output logic        mbox_valid,
    output logic        mbox_pass,
    output logic [31:0] mbox_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [31:0]           adr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  wr_q;
    logic                  accept;
    logic                  in_resp;
    logic                  adr_oob;
    logic                  mbox_hit;
    logic                  ram_we;
    logic [AW-1:0]         rd_idx;
    logic [31:0]           ram_q;

    assign accept  = (state_q == ST_IDLE) && (bus.memwrite || bus.memread);
    assign in_resp = (state_q == ST_RESP);
    assign adr_oob = (adr_q[31:AW+2] != '0);
    assign ram_we  = in_resp && wr_q && !adr_oob && !mbox_hit;

    // In IDLE the RAM is read with the incoming address so the word is ready
    // even when RESP follows the accept edge directly (no wait states).
    assign rd_idx = (state_q == ST_IDLE) ? bus.dataadr[AW+1:2] : adr_q[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - WAIT_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.memready = 1'b0;
        bus.readdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.memready = 1'b1;
                if (!adr_oob) begin
                    bus.readdata = ram_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Simultaneous memwrite and memread is a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            oob     <= 1'b0;
        end else begin
            if (accept) begin
                adr_q   <= bus.dataadr;
                wdata_q <= bus.writedata;
                be_q    <= bus.byteen;
                wr_q    <= bus.memwrite;
            end
            if (in_resp && adr_oob && !mbox_hit) begin
                oob <= 1'b1;
            end
        end
    end

    dmem_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .wadr  (adr_q[AW+1:2]),
        .wdata (wdata_q),
        .radr  (rd_idx),
        .rdata (ram_q)
    );

`ifdef DMEM_RESP_MAILBOX_EN
    // Full 32-bit match; byte enables do not apply to the mailbox.
    assign mbox_hit = wr_q && (adr_q == MAILBOX_ADR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mbox_valid <= 1'b0;
            mbox_pass  <= 1'b0;
            mbox_data  <= '0;
        end else if (in_resp && mbox_hit) begin
            mbox_valid <= 1'b1;
            mbox_pass  <= (wdata_q == EXPECT_DATA);
            mbox_data  <= wdata_q;
        end
    end
`else
    logic unused_mbox_cfg;

    assign unused_mbox_cfg = ^{MAILBOX_ADR, EXPECT_DATA, adr_q[1:0]};
    assign mbox_hit        = 1'b0;
    assign mbox_valid      = 1'b0;
    assign mbox_pass       = 1'b0;
    assign mbox_data       = '0;
`endif
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp
//   Self-checking bench for dmem_resp. Two instances share clock and reset:
//   u_dut (64 words, 2 wait states) and u_dut0 (64 words, no wait states).
//   Expected values come from a word-array model of memory plus sticky flag
//   models maintained by the bench.
module tb_dmem_resp;
    localparam int          DEPTH = 64;
    localparam int          WAITC = 2;
    localparam logic [31:0] MBOX  = 32'h0000_0ffc;
    localparam logic [31:0] EXPD  = 32'h0000_0015;
`ifdef DMEM_RESP_MAILBOX_EN
    localparam bit MBOX_EN = 1'b1;
`else
    localparam bit MBOX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        oob, mbox_valid, mbox_pass;
    logic [31:0] mbox_data;
    logic        oob0, mbox_valid0, mbox_pass0;
    logic [31:0] mbox_data0;

    dmem_resp_if bus ();
    dmem_resp_if bus0 ();

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .oob        (oob),
        .mbox_valid (mbox_valid),
        .mbox_pass  (mbox_pass),
        .mbox_data  (mbox_data)
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus0),
        .oob        (oob0),
        .mbox_valid (mbox_valid0),
        .mbox_pass  (mbox_pass0),
        .mbox_data  (mbox_data0)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_m  [DEPTH];
    logic [31:0] mem0_m [DEPTH];
    logic        oob_m = 1'b0;
    logic        mv_m  = 1'b0;
    logic        mp_m  = 1'b0;
    logic [31:0] md_m  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic we, input logic re,
                         input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] be);
        if (sel) begin
            bus0.memwrite = we; bus0.memread = re; bus0.dataadr = adr;
            bus0.writedata = wd; bus0.byteen = be;
        end else begin
            bus.memwrite = we; bus.memread = re; bus.dataadr = adr;
            bus.writedata = wd; bus.byteen = be;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus0.memready : bus.memready;
    endfunction

    function automatic logic [31:0] rdat(input bit sel);
        return sel ? bus0.readdata : bus.readdata;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // One complete transaction: drive, wait (bounded) for memready, check
    // latency and load data, release, then check the strobe drops and flags.
    task automatic xact(input bit sel, input logic we, input logic re,
                        input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] be,
                        input string tag);
        int          n;
        logic        got;
        logic [31:0] wl, exp_rd;
        bit          inr, is_mbox;
        wl      = adr >> 2;
        inr     = (wl < DEPTH);
        is_mbox = MBOX_EN && we && (adr == MBOX);
        exp_rd  = '0;
        if (inr) exp_rd = sel ? mem0_m[wl[5:0]] : mem_m[wl[5:0]];
        @(negedge clk);
        drive(sel, we, re, adr, wd, be);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = rdy(sel);
        end
        check({tag, "_latency"}, 32'(n), sel ? 32'd1 : 32'(WAITC + 1));
        if (!we) check({tag, "_rdata"}, rdat(sel), exp_rd);
        drive(sel, 1'b0, 1'b0, '0, '0, 4'h0);
        if (is_mbox) begin
            mv_m = 1'b1; md_m = wd; mp_m = (wd == EXPD);
        end else if (!inr) begin
            if (!sel) oob_m = 1'b1;
        end else if (we) begin
            if (sel) mem0_m[wl[5:0]] = merge(mem0_m[wl[5:0]], wd, be);
            else     mem_m[wl[5:0]]  = merge(mem_m[wl[5:0]], wd, be);
        end
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, 32'(rdy(sel)), 32'd0);
        check({tag, "_rdata_idle"}, rdat(sel), 32'd0);
        if (!sel) begin
            check({tag, "_oob"}, 32'(oob), 32'(oob_m));
            check({tag, "_mbox_valid"}, 32'(mbox_valid), 32'(mv_m));
            check({tag, "_mbox_pass"}, 32'(mbox_pass), 32'(mp_m));
            check({tag, "_mbox_data"}, mbox_data, md_m);
        end
    endtask

    initial begin
        logic [31:0] old8;
        int          k;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_memready", 32'(bus.memready), 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_oob", 32'(oob), 32'd0);
        check("rst_mbox_valid", 32'(mbox_valid), 32'd0);
        check("rst_mbox_pass", 32'(mbox_pass), 32'd0);
        check("rst_mbox_data", mbox_data, 32'd0);
        check("rst0_memready", 32'(bus0.memready), 32'd0);
        check("rst0_readdata", bus0.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read and partial byte write.
        xact(1'b0, 1'b1, 1'b0, 32'h14, 32'h5500_00ff, 4'hf, "wr14");
        xact(1'b0, 1'b0, 1'b1, 32'h14, '0, 4'h0, "rd14");
        check("rd14_value", mem_m[5], 32'h5500_00ff);
        xact(1'b0, 1'b1, 1'b0, 32'h20, 32'hffff_ffff, 4'hf, "wr20_full");
        xact(1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0012, 4'b0001, "wr20_byte");
        xact(1'b0, 1'b0, 1'b1, 32'h20, '0, 4'h0, "rd20");
        check("rd20_value", mem_m[8], 32'hffff_ff12);

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++) begin
            xact(1'b0, 1'b1, 1'b0, 32'(w * 4), $urandom, 4'hf, "init");
        end

        // Random in-range traffic, mixing byte enables, offsets and dual strobes.
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            case (op)
                0, 1:    xact(1'b0, 1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
                2:       xact(1'b0, 1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_rd");
                default: xact(1'b0, 1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_both");
            endcase
        end

        // Mailbox.
`ifdef DMEM_RESP_MAILBOX_EN
        xact(1'b0, 1'b1, 1'b0, MBOX, 32'd21, 4'h0, "mbox21");
        check("mbox21_valid", 32'(mbox_valid), 32'd1);
        check("mbox21_pass", 32'(mbox_pass), 32'd1);
        check("mbox21_data", mbox_data, 32'd21);
        xact(1'b0, 1'b1, 1'b0, MBOX, 32'd7, 4'hf, "mbox7");
        check("mbox7_valid", 32'(mbox_valid), 32'd1);
        check("mbox7_pass", 32'(mbox_pass), 32'd0);
        check("mbox7_data", mbox_data, 32'd7);
`else
        xact(1'b0, 1'b1, 1'b0, MBOX, 32'd21, 4'hf, "mbox_off");
        check("mbox_off_valid", 32'(mbox_valid), 32'd0);
        check("mbox_off_oob", 32'(oob), 32'd1);
`endif

        // Out of range: dropped write, zero read, sticky oob, no aliasing.
        xact(1'b0, 1'b1, 1'b0, 32'h100, 32'hdead_beef, 4'hf, "oob_wr");
        xact(1'b0, 1'b0, 1'b1, 32'h100, '0, 4'h0, "oob_rd");
        check("oob_flag", 32'(oob), 32'd1);
        for (int w = 0; w < DEPTH; w++) begin
            xact(1'b0, 1'b0, 1'b1, 32'(w * 4), '0, 4'h0, "scan");
        end

        // Reset during WAIT of a write aborts it.
        old8 = mem_m[2];
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h8, ~old8, 4'hf);
        @(posedge clk); #1;
        check("abort_in_wait", 32'(bus.memready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        oob_m = 1'b0; mv_m = 1'b0; mp_m = 1'b0; md_m = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_rst_ready", 32'(bus.memready), 32'd0);
        end
        check("abort_rst_oob", 32'(oob), 32'd0);
        check("abort_rst_mbox_valid", 32'(mbox_valid), 32'd0);
        check("abort_rst_mbox_data", mbox_data, 32'd0);
        check("abort_rst_readdata", bus.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_post_ready", 32'(bus.memready), 32'd0);
        end
        xact(1'b0, 1'b0, 1'b1, 32'h8, '0, 4'h0, "abort_rd8");
        check("abort_rd8_model", mem_m[2], old8);

        // Zero-wait instance: 8 back-to-back reads, memready every other cycle.
        for (int w = 0; w < 8; w++) begin
            xact(1'b1, 1'b1, 1'b0, 32'(w * 4), $urandom, 4'hf, "b2b_init");
        end
        @(negedge clk);
        k = 0;
        drive(1'b1, 1'b0, 1'b1, 32'((7 - k) * 4), '0, 4'h0);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            check("b2b_ready", 32'(rdy(1'b1)), 32'((c % 2) == 0));
            if (rdy(1'b1) && k < 8) begin
                check("b2b_rdata", rdat(1'b1), mem0_m[7 - k]);
                k++;
                if (k < 8) drive(1'b1, 1'b0, 1'b1, 32'((7 - k) * 4), '0, 4'h0);
                else       drive(1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
            end
        end
        check("b2b_count", 32'(k), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
